// File: rtl/mips86_rom_pkg.sv
// Shared definitions for the boot-ROM word fetcher.
//   fetch_state_t  : fetcher FSM state encoding
//   WORD_BYTES     : bytes per MIPS word
//   BYTE_WIDTH     : ROM data port width
//   assemble_word  : packs four bytes (b0 at the lowest address) into a word
package mips86_rom_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_LO  = 3'd1,
      RD_HI  = 3'd2,
      CAP_HI = 3'd3,
      RESP   = 3'd4
   } fetch_state_t;

   localparam int WORD_BYTES = 4;
   localparam int BYTE_WIDTH = 8;

   // b0 is the byte at the word address; big-endian puts it in the MSB.
   function automatic logic [WORD_BYTES*BYTE_WIDTH-1:0] assemble_word(
      input logic [BYTE_WIDTH-1:0] b0,
      input logic [BYTE_WIDTH-1:0] b1,
      input logic [BYTE_WIDTH-1:0] b2,
      input logic [BYTE_WIDTH-1:0] b3,
      input logic                  big_endian
   );
      logic [WORD_BYTES*BYTE_WIDTH-1:0] word;
      if (big_endian) begin
         word = {b0, b1, b2, b3};
      end else begin
         word = {b3, b2, b1, b0};
      end
      return word;
   endfunction

endpackage

// File: rtl/rom_word_fetcher_if.sv
// Request/response channel between a fetch client and rom_word_fetcher.
//   req_valid/req_ready/req_addr : word fetch request (byte address)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data/rsp_err             : assembled word, error flag
// master = fetch client, slave = rom_word_fetcher.
interface rom_word_fetcher_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_data;
   logic                  rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/rom_word_assembler.sv
// Byte capture and word assembly for rom_word_fetcher.
//   clk, rst_n       : clock, async active-low reset
//   i_clear          : new request accepted, zero the response word
//   i_cap_lo         : ROM ports carry bytes 0/1 this cycle
//   i_cap_hi         : ROM ports carry bytes 2/3 this cycle, build the word
//   i_rom_data(_a)   : ROM port 0 / port A read data
//   o_rsp_data       : registered assembled word
module rom_word_assembler
   import mips86_rom_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_clear,
   input  logic                               i_cap_lo,
   input  logic                               i_cap_hi,
   input  logic [BYTE_WIDTH-1:0]              i_rom_data,
   input  logic [BYTE_WIDTH-1:0]              i_rom_data_a,
   output logic [WORD_BYTES*BYTE_WIDTH-1:0]   o_rsp_data
);

   logic [BYTE_WIDTH-1:0]            r_b0;
   logic [BYTE_WIDTH-1:0]            r_b1;
   logic [WORD_BYTES*BYTE_WIDTH-1:0] r_rsp_data;

   // Low byte pair holding registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b0 <= '0;
         r_b1 <= '0;
      end else if (i_cap_lo) begin
         r_b0 <= i_rom_data;
         r_b1 <= i_rom_data_a;
      end else begin
         r_b0 <= r_b0;
         r_b1 <= r_b1;
      end
   end

   // Response word: the high pair is taken straight off the ROM ports so the
   // word is ready on the same edge that leaves CAP_HI.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_data <= '0;
      end else if (i_clear) begin
         r_rsp_data <= '0;
      end else if (i_cap_hi) begin
         r_rsp_data <= assemble_word(r_b0, r_b1, i_rom_data, i_rom_data_a, BIG_ENDIAN);
      end else begin
         r_rsp_data <= r_rsp_data;
      end
   end

   assign o_rsp_data = r_rsp_data;

endmodule

// File: rtl/rom_word_fetcher.sv
// Boot-ROM word fetcher: reads a 32-bit word from the dual-port byte ROM,
// two bytes per cycle, and returns it on a valid/ready response channel.
// Misaligned or out-of-range addresses get an error response without a
// ROM access.
//   clk, rst_n          : clock, async active-low reset
//   bus                 : request/response channel (slave side)
//   o_rom_select(_a)    : ROM port 0 / port A byte address (0 when idle)
//   i_rom_data(_a)      : ROM port 0 / port A data, one clock after select
module rom_word_fetcher
   import mips86_rom_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ROM_SIZE   = 128,
   parameter int BIG_ENDIAN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rom_word_fetcher_if.slave     bus,
   output logic [ADDR_WIDTH-1:0] o_rom_select,
   output logic [ADDR_WIDTH-1:0] o_rom_select_a,
   input  logic [BYTE_WIDTH-1:0] i_rom_data,
   input  logic [BYTE_WIDTH-1:0] i_rom_data_a
);

   // Highest legal word address, one bit wider so a huge address cannot wrap.
   localparam logic [ADDR_WIDTH:0] LP_LAST_WORD = (ADDR_WIDTH+1)'(ROM_SIZE - WORD_BYTES);

   fetch_state_t          r_state;
   fetch_state_t          w_next_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_req_ready;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic                  w_accept;
   logic                  w_addr_bad;
   logic [ADDR_WIDTH-1:0] w_sel;
   logic [ADDR_WIDTH-1:0] w_sel_a;
   logic [31:0]           w_rsp_data;

   assign w_accept   = bus.req_valid & r_req_ready;
   assign w_addr_bad = (bus.req_addr[1:0] != 2'b00) ||
                       ({1'b0, bus.req_addr} > LP_LAST_WORD);

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_addr_bad) begin
                  w_next_state = RESP;
               end else begin
                  w_next_state = RD_LO;
               end
            end else begin
               w_next_state = IDLE;
            end
         end
         RD_LO:   w_next_state = RD_HI;
         RD_HI:   w_next_state = CAP_HI;
         CAP_HI:  w_next_state = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = RESP;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // ROM select addresses, driven only while a read pair is in flight.
   always_comb begin
      w_sel   = '0;
      w_sel_a = '0;
      case (r_state)
         RD_LO: begin
            w_sel   = r_addr;
            w_sel_a = r_addr + ADDR_WIDTH'(1);
         end
         RD_HI: begin
            w_sel   = r_addr + ADDR_WIDTH'(2);
            w_sel_a = r_addr + ADDR_WIDTH'(3);
         end
         default: begin
            w_sel   = '0;
            w_sel_a = '0;
         end
      endcase
   end

   // State, latched address and registered handshake flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_req_ready <= (w_next_state == IDLE);
         r_rsp_valid <= (w_next_state == RESP);
         if (w_accept) begin
            r_addr    <= bus.req_addr;
            r_rsp_err <= w_addr_bad;
         end else begin
            r_addr    <= r_addr;
            r_rsp_err <= r_rsp_err;
         end
      end
   end

   rom_word_assembler #(
      .BIG_ENDIAN (BIG_ENDIAN != 0)
   ) u_assembler (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (w_accept),
      .i_cap_lo     (r_state == RD_HI),
      .i_cap_hi     (r_state == CAP_HI),
      .i_rom_data   (i_rom_data),
      .i_rom_data_a (i_rom_data_a),
      .o_rsp_data   (w_rsp_data)
   );

   assign bus.req_ready  = r_req_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_err    = r_rsp_err;
   assign bus.rsp_data   = w_rsp_data;
   assign o_rom_select   = w_sel;
   assign o_rom_select_a = w_sel_a;

endmodule

// File: tb/tb_rom_word_fetcher.sv
// Directed self-checking bench for rom_word_fetcher: a big-endian and a
// little-endian instance, each fed by its own registered dual-port ROM model.
module tb_rom_word_fetcher;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rom_word_fetcher_if #(.ADDR_WIDTH(32)) bus_be ();
   rom_word_fetcher_if #(.ADDR_WIDTH(32)) bus_le ();

   logic [31:0] sel_be, sel_a_be, sel_le, sel_a_le;
   logic [7:0]  dat_be, dat_a_be, dat_le, dat_a_le;
   logic [7:0]  rom [0:127];

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] b2b_addr [3];
   logic [31:0] b2b_exp  [3];
   int          rsp_cyc  [3];
   int          n_acc;
   int          n_rsp;
   logic        accepting;

   rom_word_fetcher #(.ADDR_WIDTH(32), .BYTE_WIDTH(8), .ROM_SIZE(128), .BIG_ENDIAN(1)) dut_be (
      .clk(clk), .rst_n(rst_n), .bus(bus_be),
      .o_rom_select(sel_be), .o_rom_select_a(sel_a_be),
      .i_rom_data(dat_be), .i_rom_data_a(dat_a_be)
   );

   rom_word_fetcher #(.ADDR_WIDTH(32), .BYTE_WIDTH(8), .ROM_SIZE(128), .BIG_ENDIAN(0)) dut_le (
      .clk(clk), .rst_n(rst_n), .bus(bus_le),
      .o_rom_select(sel_le), .o_rom_select_a(sel_a_le),
      .i_rom_data(dat_le), .i_rom_data_a(dat_a_le)
   );

   // Registered ROM read ports: data appears one clock after the select.
   always @(posedge clk) begin
      dat_be   <= rom[sel_be[6:0]];
      dat_a_be <= rom[sel_a_be[6:0]];
      dat_le   <= rom[sel_le[6:0]];
      dat_a_le <= rom[sel_a_le[6:0]];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One complete fetch on the big-endian instance with rsp_ready high.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
      check("idle_req_ready", 32'(bus_be.req_ready), 32'd1);
      bus_be.req_valid = 1'b1;
      bus_be.req_addr  = addr;
      step();
      bus_be.req_valid = 1'b0;
      if (exp_err) begin
         check("err_rsp_valid", 32'(bus_be.rsp_valid), 32'd1);
         check("err_rsp_err",   32'(bus_be.rsp_err),   32'd1);
         check("err_rsp_data",  bus_be.rsp_data,       32'd0);
         check("err_sel",       sel_be,                32'd0);
         check("err_sel_a",     sel_a_be,              32'd0);
      end else begin
         check("rdlo_sel",       sel_be,                addr);
         check("rdlo_sel_a",     sel_a_be,              addr + 32'd1);
         check("rdlo_rsp_valid", 32'(bus_be.rsp_valid), 32'd0);
         step();
         check("rdhi_sel",       sel_be,                addr + 32'd2);
         check("rdhi_sel_a",     sel_a_be,              addr + 32'd3);
         step();
         check("cap_sel",        sel_be,                32'd0);
         check("cap_rsp_valid",  32'(bus_be.rsp_valid), 32'd0);
         step();
         check("rsp_valid",      32'(bus_be.rsp_valid), 32'd1);
         check("rsp_data",       bus_be.rsp_data,       exp_data);
         check("rsp_err",        32'(bus_be.rsp_err),   32'd0);
         check("rsp_req_ready",  32'(bus_be.req_ready), 32'd0);
      end
      step();
      check("done_rsp_valid", 32'(bus_be.rsp_valid), 32'd0);
      check("done_req_ready", 32'(bus_be.req_ready), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 8'(i) ^ 8'hA5;
      rom[0] = 8'h3C; rom[1] = 8'h08; rom[2] = 8'h12; rom[3] = 8'h34;
      rom[4] = 8'h8D; rom[5] = 8'h09; rom[6] = 8'h00; rom[7] = 8'h04;
      rom[124] = 8'hDE; rom[125] = 8'hAD; rom[126] = 8'hBE; rom[127] = 8'hEF;

      rst_n = 1'b0;
      bus_be.req_valid = 1'b0; bus_be.req_addr = 32'd0; bus_be.rsp_ready = 1'b1;
      bus_le.req_valid = 1'b0; bus_le.req_addr = 32'd0; bus_le.rsp_ready = 1'b1;
      step();
      step();

      // Reset state
      check("rst_req_ready", 32'(bus_be.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus_be.rsp_valid), 32'd0);
      check("rst_rsp_err",   32'(bus_be.rsp_err),   32'd0);
      check("rst_rsp_data",  bus_be.rsp_data,       32'd0);
      check("rst_sel",       sel_be,                32'd0);
      check("rst_sel_a",     sel_a_be,              32'd0);

      // Release reset together with a request: accepted on the first edge.
      rst_n = 1'b1;
      do_fetch(32'h0000_0000, 32'h3C08_1234, 1'b0);
      do_fetch(32'h0000_0004, 32'h8D09_0004, 1'b0);
      do_fetch(32'h0000_0002, 32'h0000_0000, 1'b1);
      do_fetch(32'h0000_007C, 32'hDEAD_BEEF, 1'b0);
      do_fetch(32'h0000_0080, 32'h0000_0000, 1'b1);
      do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 1'b1);

      // Little-endian instance
      bus_le.req_valid = 1'b1;
      bus_le.req_addr  = 32'd0;
      step();
      bus_le.req_valid = 1'b0;
      check("le_sel0",   sel_le,   32'd0);
      check("le_sel_a0", sel_a_le, 32'd1);
      step();
      check("le_sel1",   sel_le,   32'd2);
      check("le_sel_a1", sel_a_le, 32'd3);
      step();
      step();
      check("le_rsp_valid", 32'(bus_le.rsp_valid), 32'd1);
      check("le_rsp_data",  bus_le.rsp_data,       32'h3412_083C);
      step();
      check("le_done_valid", 32'(bus_le.rsp_valid), 32'd0);

      // Backpressure in RESP with a queued request
      bus_be.rsp_ready = 1'b0;
      bus_be.req_valid = 1'b1;
      bus_be.req_addr  = 32'd4;
      step();
      bus_be.req_valid = 1'b0;
      step();
      step();
      step();
      bus_be.req_valid = 1'b1;
      bus_be.req_addr  = 32'd8;
      for (int k = 0; k < 6; k++) begin
         check("bp_rsp_valid", 32'(bus_be.rsp_valid), 32'd1);
         check("bp_rsp_data",  bus_be.rsp_data,       32'h8D09_0004);
         check("bp_rsp_err",   32'(bus_be.rsp_err),   32'd0);
         check("bp_req_ready", 32'(bus_be.req_ready), 32'd0);
         step();
      end
      bus_be.rsp_ready = 1'b1;
      step();
      check("bp_release_valid", 32'(bus_be.rsp_valid), 32'd0);
      check("bp_release_ready", 32'(bus_be.req_ready), 32'd1);
      step();
      bus_be.req_valid = 1'b0;
      check("bp_queued_sel",   sel_be,   32'd8);
      check("bp_queued_sel_a", sel_a_be, 32'd9);
      step();
      step();
      step();
      check("bp_queued_valid", 32'(bus_be.rsp_valid), 32'd1);
      check("bp_queued_data",  bus_be.rsp_data,       32'hADAC_AFAE);
      step();

      // Reset during RD_HI
      bus_be.req_valid = 1'b1;
      bus_be.req_addr  = 32'd4;
      step();
      bus_be.req_valid = 1'b0;
      step();
      check("mid_rdhi_sel", sel_be, 32'd6);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sel",       sel_be,                32'd0);
      check("mid_rst_sel_a",     sel_a_be,              32'd0);
      check("mid_rst_rsp_valid", 32'(bus_be.rsp_valid), 32'd0);
      check("mid_rst_rsp_data",  bus_be.rsp_data,       32'd0);
      check("mid_rst_req_ready", 32'(bus_be.req_ready), 32'd1);
      step();
      step();
      rst_n = 1'b1;
      step();
      do_fetch(32'h0000_0000, 32'h3C08_1234, 1'b0);

      // Back-to-back requests, req_valid held high
      b2b_addr[0] = 32'h00; b2b_exp[0] = 32'h3C08_1234;
      b2b_addr[1] = 32'h04; b2b_exp[1] = 32'h8D09_0004;
      b2b_addr[2] = 32'h7C; b2b_exp[2] = 32'hDEAD_BEEF;
      n_acc = 0;
      n_rsp = 0;
      bus_be.req_addr  = b2b_addr[0];
      bus_be.req_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         accepting = bus_be.req_valid && bus_be.req_ready;
         step();
         if (accepting) begin
            n_acc++;
            if (n_acc < 3) bus_be.req_addr = b2b_addr[n_acc];
            else bus_be.req_valid = 1'b0;
         end
         if (bus_be.rsp_valid) begin
            if (n_rsp < 3) begin
               check("b2b_data", bus_be.rsp_data, b2b_exp[n_rsp]);
               rsp_cyc[n_rsp] = c;
            end
            n_rsp++;
         end
      end
      bus_be.req_valid = 1'b0;
      check("b2b_rsp_count", 32'(n_rsp), 32'd3);
      check("b2b_acc_count", 32'(n_acc), 32'd3);
      if (n_rsp >= 3) begin
         check("b2b_spacing0", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd5);
         check("b2b_spacing1", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'd5);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
